pipe_trace: RTL and testbench

PIPE_TRACE -- requirements
Module: pipe_trace

---
 rtl/pipe_trace.sv | 163 ++++++++++++++++
 tb/tb_pipe_trace.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_trace.sv
// rtl/pipe_trace.sv - triggered pipeline trace buffer with pre/post-trigger capture and stream readout
// Optional TRACE_CHANGE_ONLY_EN: store a valid sample only when its data differs from the last stored one.
module pipe_trace #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 48,
  parameter int DEPTH    = 64,
  parameter int TICK_W   = 16
) (
  input  logic                         iw_clk,
  input  logic                         iw_rst,
  input  logic                         iw_arm,
  input  logic                         iw_valid,
  input  logic [CHANNELS*WIDTH-1:0]    iw_data,
  input  logic                         iw_trig,
  input  logic [$clog2(DEPTH)-1:0]     iw_post_cnt,
  output logic                         ow_rd_valid,
  input  logic                         iw_rd_ready,
  output logic [CHANNELS*WIDTH-1:0]    ow_rd_data,
  output logic [TICK_W-1:0]            ow_rd_tick,
  output logic                         ow_rd_last,
  output logic [1:0]                   ow_state,
  output logic                         ow_wrapped
);

  localparam int DW = CHANNELS * WIDTH;
  localparam int AW = $clog2(DEPTH);
  localparam int EW = TICK_W + DW;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_POST  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t          state;
  logic [EW-1:0]   mem [DEPTH];
  logic [TICK_W-1:0] tick;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   remaining;
  logic [AW:0]     count;
  logic            wrapped;

  logic            keep;
  logic            store;
  logic            full;
  logic [AW-1:0]   wr_nxt;
  logic [AW:0]     cnt_nxt;
  logic [AW-1:0]   rd_start;
  logic            rd_valid_c;
  logic            xfer;

`ifdef TRACE_CHANGE_ONLY_EN
  logic [DW-1:0]   last_data;

  // count==0 marks the first sample after arm; the trigger sample is always kept
  always_comb begin
    keep = (count == '0) || (iw_data != last_data) || (state == S_ARMED && iw_trig);
  end

  always_ff @(posedge iw_clk) begin
    if (iw_rst)
      last_data <= '0;
    else if (store)
      last_data <= iw_data;
  end
`else
  always_comb begin
    keep = 1'b1;
  end
`endif

  always_comb begin
    store      = (state == S_ARMED || state == S_POST) && iw_valid && keep;
    full       = (count == (AW+1)'(DEPTH));
    wr_nxt     = store ? wr_ptr + 1'b1 : wr_ptr;
    cnt_nxt    = (store && !full) ? count + 1'b1 : count;
    // oldest entry after this cycle's store; with a full buffer it is the write slot
    rd_start   = wr_nxt - cnt_nxt[AW-1:0];
    rd_valid_c = (state == S_DONE) && (count != '0);
    xfer       = rd_valid_c && iw_rd_ready;
  end

  always_ff @(posedge iw_clk) begin
    if (store)
      mem[wr_ptr] <= {tick, iw_data};
  end

  always_ff @(posedge iw_clk) begin
    if (iw_rst) begin
      state     <= S_IDLE;
      tick      <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      remaining <= '0;
      count     <= '0;
      wrapped   <= 1'b0;
    end else begin
      tick <= tick + 1'b1;
      if (store) begin
        wr_ptr <= wr_nxt;
        count  <= cnt_nxt;
        if (full)
          wrapped <= 1'b1;
      end
      case (state)
        S_IDLE: begin
          if (iw_arm) begin
            state   <= S_ARMED;
            wr_ptr  <= '0;
            count   <= '0;
            wrapped <= 1'b0;
          end
        end
        S_ARMED: begin
          if (iw_trig) begin
            remaining <= iw_post_cnt;
            if (iw_post_cnt == '0) begin
              state  <= S_DONE;
              rd_ptr <= rd_start;
            end else begin
              state <= S_POST;
            end
          end
        end
        S_POST: begin
          if (store) begin
            remaining <= remaining - 1'b1;
            if (remaining == AW'(1)) begin
              state  <= S_DONE;
              rd_ptr <= rd_start;
            end
          end
        end
        S_DONE: begin
          if (count == '0) begin
            state <= S_IDLE;
          end else if (xfer) begin
            rd_ptr <= rd_ptr + 1'b1;
            count  <= count - 1'b1;
            if (count == (AW+1)'(1))
              state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  logic [EW-1:0] rd_entry;

  always_comb begin
    rd_entry    = mem[rd_ptr];
    ow_rd_valid = rd_valid_c;
    ow_rd_data  = rd_valid_c ? rd_entry[DW-1:0] : '0;
    ow_rd_tick  = rd_valid_c ? rd_entry[EW-1:DW] : '0;
    ow_rd_last  = rd_valid_c && (count == (AW+1)'(1));
    ow_state    = state;
    ow_wrapped  = wrapped;
  end

endmodule

// File: tb/tb_pipe_trace.sv
// tb/tb_pipe_trace.sv - directed scoreboard bench for pipe_trace (CHANNELS=2, WIDTH=8, DEPTH=8)
module tb_pipe_trace;

  logic        clk = 1'b0;
  logic        rst;
  logic        arm;
  logic        valid;
  logic [15:0] data;
  logic        trig;
  logic [2:0]  post_cnt;
  logic        rd_ready;
  logic        rd_valid;
  logic [15:0] rd_data;
  logic [15:0] rd_tick;
  logic        rd_last;
  logic [1:0]  state;
  logic        wrapped;

  pipe_trace #(.CHANNELS(2), .WIDTH(8), .DEPTH(8), .TICK_W(16)) dut (
    .iw_clk(clk), .iw_rst(rst), .iw_arm(arm), .iw_valid(valid), .iw_data(data),
    .iw_trig(trig), .iw_post_cnt(post_cnt), .ow_rd_valid(rd_valid), .iw_rd_ready(rd_ready),
    .ow_rd_data(rd_data), .ow_rd_tick(rd_tick), .ow_rd_last(rd_last),
    .ow_state(state), .ow_wrapped(wrapped)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] tick;
    logic [15:0] data;
  } ent_t;

  ent_t        sb[$];
  logic [15:0] mtick;
  logic        mwrapped;
  logic        mfirst;
  logic [15:0] mlast;
  int          checks = 0;
  int          errors = 0;
  int          n_read;
  int          exp_n;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (rst) mtick = '0;
    else     mtick = mtick + 16'd1;
    #1;
  endtask

  task automatic model_store(input logic [15:0] d, input logic t);
`ifdef TRACE_CHANGE_ONLY_EN
    if (!mfirst && !t && d == mlast) return;
`endif
    if (sb.size() == 8) begin
      void'(sb.pop_front());
      mwrapped = 1'b1;
    end
    sb.push_back('{tick: mtick, data: d});
    mfirst = 1'b0;
    mlast  = d;
  endtask

  task automatic sample(input logic [15:0] d, input logic t, input logic [2:0] p, input logic v);
    valid = v; data = d; trig = t; post_cnt = p;
    if (v) model_store(d, t);
    step();
    valid = 1'b0; trig = 1'b0;
  endtask

  task automatic do_arm();
    arm = 1'b1;
    step();
    arm = 1'b0;
    sb.delete();
    mwrapped = 1'b0;
    mfirst = 1'b1;
    chk("armed_state", state, 2'd1);
    chk("armed_wrapped", wrapped, 1'b0);
  endtask

  task automatic drain(input int stall_idx, output int n);
    int budget;
    n = 0;
    budget = 0;
    rd_ready = 1'b1;
    while (sb.size() > 0 && budget < 60) begin
      budget++;
      if (rd_valid) begin
        if (n == stall_idx) begin
          rd_ready = 1'b0;
          repeat (3) begin
            step();
            chk("stall_valid", rd_valid, 1'b1);
            chk("stall_data", rd_data, sb[0].data);
            chk("stall_tick", rd_tick, sb[0].tick);
          end
          rd_ready = 1'b1;
        end
        chk("rd_data", rd_data, sb[0].data);
        chk("rd_tick", rd_tick, sb[0].tick);
        chk("rd_last", rd_last, sb.size() == 1);
        void'(sb.pop_front());
        n++;
      end
      step();
    end
    rd_ready = 1'b0;
    chk("drain_left", sb.size(), 0);
    chk("idle_after_drain", state, 2'd0);
    chk("valid_after_drain", rd_valid, 1'b0);
  endtask

  initial begin
    rst = 1'b1; arm = 1'b0; valid = 1'b0; data = '0; trig = 1'b0; post_cnt = '0; rd_ready = 1'b0;
    mtick = '0; mwrapped = 1'b0; mfirst = 1'b1; mlast = '0;
    step(); step();
    rst = 1'b0;
    chk("rst_state", state, 2'd0);
    chk("rst_valid", rd_valid, 1'b0);
    chk("rst_wrapped", wrapped, 1'b0);
    chk("rst_data", rd_data, 16'h0);
    chk("rst_last", rd_last, 1'b0);

    // basic capture with pre/post samples and a readout stall
    while (mtick != 16'd10) step();
    do_arm();
    sample(16'h0101, 1'b0, 3'd0, 1'b1);
    sample(16'h0202, 1'b0, 3'd0, 1'b1);
    sample(16'h0303, 1'b0, 3'd0, 1'b1);
    sample(16'h0404, 1'b1, 3'd2, 1'b1);
    chk("post_state", state, 2'd2);
    sample(16'h0505, 1'b1, 3'd0, 1'b1);
    chk("post_state2", state, 2'd2);
    sample(16'h0606, 1'b0, 3'd0, 1'b1);
    chk("done_state", state, 2'd3);
    chk("first_tick", sb[0].tick, 16'd11);
    chk("no_wrap", wrapped, 1'b0);
    drain(2, n_read);
    chk("n_basic", n_read, 6);

    // wrap-around: 12 samples into 8 entries, trigger on the last
    do_arm();
    for (int i = 1; i <= 12; i++)
      sample(16'(i), i == 12, 3'd0, 1'b1);
    chk("wrap_state", state, 2'd3);
    chk("wrap_flag", wrapped, mwrapped);
    chk("wrap_oldest", sb[0].data, 16'h0005);
    drain(-1, n_read);
    chk("n_wrap", n_read, 8);

    // reset mid-POST with wrapped set, then a clean capture
    do_arm();
    for (int i = 1; i <= 9; i++)
      sample(16'(16'h0100 + i), 1'b0, 3'd0, 1'b1);
    sample(16'h01AA, 1'b1, 3'd3, 1'b1);
    chk("pre_rst_state", state, 2'd2);
    chk("pre_rst_wrapped", wrapped, 1'b1);
    sample(16'h01BB, 1'b0, 3'd0, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    sb.delete();
    chk("mid_rst_state", state, 2'd0);
    chk("mid_rst_valid", rd_valid, 1'b0);
    chk("mid_rst_wrapped", wrapped, 1'b0);
    do_arm();
    sample(16'h0A0A, 1'b0, 3'd0, 1'b1);
    sample(16'h0B0B, 1'b1, 3'd0, 1'b1);
    drain(-1, n_read);
    chk("n_after_rst", n_read, 2);

    // trigger with nothing stored
    do_arm();
    sample(16'h0000, 1'b1, 3'd0, 1'b0);
    chk("empty_done", state, 2'd3);
    chk("empty_valid", rd_valid, 1'b0);
    step();
    chk("empty_idle", state, 2'd0);
    chk("empty_valid2", rd_valid, 1'b0);

    // repeated data
    do_arm();
    repeat (4) sample(16'h0707, 1'b0, 3'd0, 1'b1);
    sample(16'h0808, 1'b1, 3'd0, 1'b1);
`ifdef TRACE_CHANGE_ONLY_EN
    exp_n = 2;
`else
    exp_n = 5;
`endif
    drain(-1, n_read);
    chk("n_repeat", n_read, exp_n);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
